instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// - Initiator side of the instruction-memory read port: owns the PC, drives Instr_Addr, samples
//   Instr_rdata (combinational, same-cycle memory) and hands {instr, pc} to decode via valid/ready.
// - Sits between IMEM and the decode stage; accepts branch/jump redirects and decode back-pressure.
// PARAMETERS
// - RESET_PC   32'h0000_0000  PC loaded on reset; must be word-aligned
// - PC_STEP    4              byte increment per sequential fetch
// PORTS
// - clk             in   1   single clock, all state on rising edge
// - reset           in   1   asynchronous, active-high
// - fetch_en        in   1   1 = fetching allowed; 0 = hold PC, no new fetches
// - Instr_Addr      out  32  byte address to IMEM (= current PC)
// - Instr_rdata     in   32  instruction word returned by IMEM in the same cycle
// - redirect_valid  in   1   branch/jump taken this cycle
// - redirect_pc     in   32  target byte address
// - instr_valid     out  1   instr_out/instr_pc hold a valid fetched word
// - instr_ready     in   1   decode accepts the word this cycle
// - instr_out       out  32  fetched instruction
// - instr_pc        out  32  byte address of instr_out
// - fetch_fault     out  1   misaligned redirect trap (only with FETCH_MISALIGN_TRAP_EN, else tied 0)
// BEHAVIOUR
// - Reset (async): pc=RESET_PC, instr_valid=0, instr_out=32'h0000_0013 (NOP), instr_pc=0,
//   fetch_fault=0, state=IDLE. Reset mid-operation discards any held word immediately.
// - Instr_Addr = pc, combinational from the PC register (no other logic on the path).
// - States: IDLE -> RUN when fetch_en=1; RUN -> IDLE when fetch_en=0 (held word stays valid until
//   accepted); RUN/IDLE -> FAULT on misaligned redirect (macro only); FAULT -> RUN on aligned redirect.
// - Advance condition adv = (state==RUN) && (!instr_valid || instr_ready).
// - On adv (no redirect): instr_out<=Instr_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP.
// - Accepted with no advance (fetch_en=0 or not RUN): instr_valid<=0 on instr_valid&&instr_ready.
// - Back-pressure: instr_valid=1 && instr_ready=0 -> instr_out, instr_pc, pc all hold; no word lost
//   or duplicated.
// - Latency: word at address A appears on instr_out one cycle after pc==A with adv=1. Throughput
//   one word/cycle while instr_ready=1.
// - Redirect (highest priority, any state): pc<=redirect_pc, instr_valid<=0 (flush held word even if
//   instr_ready=1 that cycle; decode must not consume it); first target word appears 2 cycles later.
// - Simultaneous redirect and adv: redirect wins, the word at old pc is NOT captured.
// - PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, no flag.
// CONFIGURATION
// - FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 -> state=FAULT, fetch_fault=1 (registered,
//   next cycle), pc<=redirect_pc unchanged, instr_valid<=0, no fetches until an aligned redirect,
//   which clears fetch_fault and returns to RUN (or IDLE if fetch_en=0).
// - Not defined: redirect_pc[1:0] forced to 2'b00 on load; FAULT state absent; fetch_fault tied 0.
// TESTING
// - Reset, fetch_en=1, instr_ready=1, IMEM words 0x00310093,0xFFD28113,0x00944493 -> cycles 1..3
//   instr_out=those words, instr_pc=0x0,0x4,0x8, instr_valid=1 continuously.
// - Hold instr_ready=0 for 3 cycles with instr_pc=0x4 -> instr_out=0xFFD28113, pc=0x8 held; release
//   -> next word 0x00944493 at instr_pc=0x8, no duplicate/skip.
// - redirect_valid=1, redirect_pc=0x20 while instr_valid=1, instr_ready=1 -> next cycle instr_valid=0,
//   Instr_Addr=0x20; following cycle instr_pc=0x20.
// - Async reset asserted mid-stream (pc=0x14) -> instr_valid=0, pc=RESET_PC, instr_out=0x00000013
//   without waiting for clk.
// - With FETCH_MISALIGN_TRAP_EN: redirect_pc=0x22 -> fetch_fault=1, instr_valid stays 0; redirect
//   to 0x24 -> fetch_fault=0, instr_pc=0x24 two cycles later. Without: 0x22 -> fetches from 0x20.
// - pc=0xFFFFFFFC accepted -> next Instr_Addr=0x00000000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads same-cycle IMEM, presents {instr, pc} one cycle after adv; redirect wins.
// Decode back-pressure holds instr_out/instr_pc/pc; macro FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect FAULT state.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic [31:0] Instr_Addr,
   input  logic [31:0] Instr_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        fetch_fault
);

   localparam logic [31:0] STEP = 32'(PC_STEP);
   localparam logic [31:0] NOP  = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic [31:0] load_pc;
   logic        misalign;
   logic        run;
   logic        adv;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign load_pc  = redirect_pc;
`else
   logic unused_low_bits;
   assign unused_low_bits = ^redirect_pc[1:0];
   assign misalign = 1'b0;
   assign load_pc  = {redirect_pc[31:2], 2'b00};
`endif

   assign Instr_Addr = pc;
   assign adv        = run && (!instr_valid || instr_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         if (misalign)      state_nxt = FAULT;
         else if (fetch_en) state_nxt = RUN;
         else               state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (fetch_en)  state_nxt = RUN;
            RUN:     if (!fetch_en) state_nxt = IDLE;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      run         = (state == RUN);
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_fault = (state == FAULT);
`else
      fetch_fault = 1'b0;
`endif
   end

   // A redirect flushes the held word even if decode is accepting it this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         instr_valid <= 1'b0;
         instr_out   <= NOP;
         instr_pc    <= 32'h0000_0000;
      end else if (redirect_valid) begin
         pc          <= load_pc;
         instr_valid <= 1'b0;
      end else if (adv) begin
         instr_out   <= Instr_rdata;
         instr_pc    <= pc;
         instr_valid <= 1'b1;
         pc          <= pc + STEP;
      end else if (instr_valid && instr_ready) begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational IMEM model.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic [31:0] Instr_Addr;
   logic [31:0] Instr_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        fetch_fault;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .Instr_Addr     (Instr_Addr),
      .Instr_rdata    (Instr_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      case (a)
         32'h0000_0000: imem = 32'h0031_0093;
         32'h0000_0004: imem = 32'hFFD2_8113;
         32'h0000_0008: imem = 32'h0094_4493;
         default:       imem = a ^ 32'hA5A5_0000;
      endcase
   endfunction

   assign Instr_rdata = imem(Instr_Addr);

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset          = 1'b1;
      fetch_en       = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      #1;
      check_val("rst_valid", {31'b0, instr_valid}, 32'h0);
      check_val("rst_addr",  Instr_Addr, 32'h0);
      check_val("rst_out",   instr_out, 32'h0000_0013);
      check_val("rst_ipc",   instr_pc, 32'h0);
      check_val("rst_fault", {31'b0, fetch_fault}, 32'h0);
      tick();
      tick();
      reset       = 1'b0;
      fetch_en    = 1'b1;
      instr_ready = 1'b1;

      // IDLE -> RUN takes one edge, then one word per cycle
      tick();
      check_val("idle_valid", {31'b0, instr_valid}, 32'h0);
      tick();
      check_val("w0_valid", {31'b0, instr_valid}, 32'h1);
      check_val("w0_out",   instr_out, 32'h0031_0093);
      check_val("w0_pc",    instr_pc, 32'h0);
      tick();
      check_val("w1_valid", {31'b0, instr_valid}, 32'h1);
      check_val("w1_out",   instr_out, 32'hFFD2_8113);
      check_val("w1_pc",    instr_pc, 32'h4);

      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("bp_out",  instr_out, 32'hFFD2_8113);
         check_val("bp_pc",   instr_pc, 32'h4);
         check_val("bp_addr", Instr_Addr, 32'h8);
      end
      instr_ready = 1'b1;
      tick();
      check_val("w2_valid", {31'b0, instr_valid}, 32'h1);
      check_val("w2_out",   instr_out, 32'h0094_4493);
      check_val("w2_pc",    instr_pc, 32'h8);

      redirect_valid = 1'b1;
      redirect_pc    = 32'h20;
      tick();
      redirect_valid = 1'b0;
      check_val("rd_valid", {31'b0, instr_valid}, 32'h0);
      check_val("rd_addr",  Instr_Addr, 32'h20);
      tick();
      check_val("rd_tgt_pc",  instr_pc, 32'h20);
      check_val("rd_tgt_out", instr_out, 32'hA5A5_0020);
      check_val("rd_next",    Instr_Addr, 32'h24);

      redirect_valid = 1'b1;
      redirect_pc    = 32'h22;
      tick();
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      check_val("mis_fault", {31'b0, fetch_fault}, 32'h1);
      check_val("mis_valid", {31'b0, instr_valid}, 32'h0);
      tick();
      check_val("mis_fault2", {31'b0, fetch_fault}, 32'h1);
      check_val("mis_valid2", {31'b0, instr_valid}, 32'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h24;
      tick();
      redirect_valid = 1'b0;
      check_val("clr_fault", {31'b0, fetch_fault}, 32'h0);
      check_val("clr_addr",  Instr_Addr, 32'h24);
      tick();
      check_val("clr_pc",    instr_pc, 32'h24);
      check_val("clr_valid", {31'b0, instr_valid}, 32'h1);
`else
      check_val("mis_addr",  Instr_Addr, 32'h20);
      check_val("mis_fault", {31'b0, fetch_fault}, 32'h0);
      tick();
      check_val("mis_pc",    instr_pc, 32'h20);
      check_val("mis_valid", {31'b0, instr_valid}, 32'h1);
`endif

      // fetch_en low: held word survives until accepted, PC frozen
      begin
         logic [31:0] held_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
         held_pc = 32'h24;
`else
         held_pc = 32'h20;
`endif
         fetch_en    = 1'b0;
         instr_ready = 1'b0;
         tick();
         check_val("off_valid", {31'b0, instr_valid}, 32'h1);
         check_val("off_pc",    instr_pc, held_pc);
         instr_ready = 1'b1;
         tick();
         check_val("off_acc",  {31'b0, instr_valid}, 32'h0);
         check_val("off_addr", Instr_Addr, held_pc + 32'h4);
      end

      fetch_en       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      check_val("wr_addr", Instr_Addr, 32'hFFFF_FFFC);
      tick();
      check_val("wr_pc",   instr_pc, 32'hFFFF_FFFC);
      check_val("wr_next", Instr_Addr, 32'h0);

      redirect_valid = 1'b1;
      redirect_pc    = 32'h10;
      tick();
      redirect_valid = 1'b0;
      tick();
      check_val("pre_addr",  Instr_Addr, 32'h14);
      check_val("pre_valid", {31'b0, instr_valid}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check_val("arst_valid", {31'b0, instr_valid}, 32'h0);
      check_val("arst_addr",  Instr_Addr, 32'h0);
      check_val("arst_out",   instr_out, 32'h0000_0013);
      check_val("arst_ipc",   instr_pc, 32'h0);
      tick();
      reset = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
